// File: rtl/psd_iir_lpf_cascade.sv
// Multi-channel cascade of first-order IIR low-pass stages, blanked while settling; PSD_IIR_PRELOAD_EN seeds stages from first sample.
// Latency 3+tap edges from i_valid; full throughput, no backpressure (gaps in i_valid simply hold state).
module psd_iir_lpf_cascade #(
    parameter int DW   = 36,
    parameter int NCH  = 4,
    parameter int NSTG = 4,
    parameter int KW   = 4,
    parameter int MW   = 2,
    parameter int FRAC = 16,
    parameter int CNTW = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [NCH*DW-1:0]   i_data,
    input  logic [KW-1:0]       i_coef,
    input  logic [MW-1:0]       i_mod,
    input  logic                i_clr,
    output logic [NCH*DW-1:0]   o_data,
    output logic                o_valid,
    output logic                o_settled
);

    localparam int SW = DW + FRAC;
    localparam int TW = (NSTG > 1) ? $clog2(NSTG) : 1;

    typedef enum logic {ST_SETTLE, ST_RUN} state_t;
    typedef logic signed [SW-1:0] acc_t;

    // One IIR update; two extra bits keep the difference plus rounding term exact.
    function automatic acc_t iir_step(input acc_t x, input acc_t s, input logic [KW-1:0] k);
        logic signed [SW+1:0] d;
        logic signed [SW+1:0] rnd;
        d   = {{2{x[SW-1]}}, x} - {{2{s[SW-1]}}, s};
        rnd = ((SW+2)'(1) << k) >> 1;
        d   = (d + rnd) >>> k;
        return s + d[SW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_out(input acc_t s);
        acc_t t;
        t = s + (SW'(1) << (FRAC - 1));
        return DW'(t >>> FRAC);
    endfunction

    function automatic logic [CNTW-1:0] settle_load(input logic [KW-1:0] k, input logic [TW-1:0] m);
        return (CNTW'(m) + CNTW'(1)) << (k + 2);
    endfunction

    logic [KW-1:0]              coef_r, coef_q;
    logic [TW-1:0]              mod_clamp, mod_r, mod_q;
    logic                       cfg_chg;

    logic                       in_vld;
    logic [NCH-1:0][DW-1:0]     in_dat;
    logic [NSTG-1:0]            stg_en;
    logic [NSTG-1:0]            stg_vld;
    acc_t                       st     [NSTG][NCH];
    acc_t                       st_nxt [NSTG][NCH];
    acc_t                       stg_x  [NSTG][NCH];
    logic                       out_stb;
    logic [NCH-1:0][DW-1:0]     out_nxt;

    state_t                     state, state_nxt;
    logic [CNTW-1:0]            cnt, cnt_nxt;
    logic                       vld_nxt;

    // Out-of-range modes select the last stage.
    always_comb begin
        mod_clamp = TW'(NSTG - 1);
        if (int'(i_mod) < NSTG)
            mod_clamp = TW'(i_mod);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            coef_r <= '0;
            coef_q <= '0;
            mod_r  <= '0;
            mod_q  <= '0;
        end else begin
            coef_r <= i_coef;
            coef_q <= coef_r;
            mod_r  <= mod_clamp;
            mod_q  <= mod_r;
        end
    end

    assign cfg_chg = (coef_r != coef_q) || (mod_r != mod_q);

    always_comb begin
        stg_en[0] = in_vld;
        for (int j = 1; j < NSTG; j++)
            stg_en[j] = stg_vld[j-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_vld  <= 1'b0;
            in_dat  <= '0;
            stg_vld <= '0;
        end else if (i_clr) begin
            in_vld  <= 1'b0;
            stg_vld <= '0;
        end else begin
            in_vld  <= i_valid;
            stg_vld <= stg_en;
            if (i_valid)
                in_dat <= i_data;
        end
    end

    for (genvar j = 0; j < NSTG; j++) begin : g_stg
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            if (j == 0) begin : g_head
                assign stg_x[j][c] = {in_dat[c], {FRAC{1'b0}}};
            end else begin : g_tail
                assign stg_x[j][c] = st[j-1][c];
            end
            assign st_nxt[j][c] = iir_step(stg_x[j][c], st[j][c], coef_r);
        end
    end

`ifdef PSD_IIR_PRELOAD_EN
    logic pre_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            pre_pend <= 1'b1;
        else if (i_clr)
            pre_pend <= 1'b1;
        else if (in_vld)
            pre_pend <= 1'b0;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < NSTG; j++)
                for (int c = 0; c < NCH; c++)
                    st[j][c] <= '0;
        end else if (i_clr) begin
            for (int j = 0; j < NSTG; j++)
                for (int c = 0; c < NCH; c++)
                    st[j][c] <= '0;
        end else begin
`ifdef PSD_IIR_PRELOAD_EN
            if (in_vld && pre_pend) begin
                for (int j = 0; j < NSTG; j++)
                    for (int c = 0; c < NCH; c++)
                        st[j][c] <= stg_x[0][c];
            end else begin
`else
            begin
`endif
                for (int j = 0; j < NSTG; j++)
                    if (stg_en[j])
                        for (int c = 0; c < NCH; c++)
                            st[j][c] <= st_nxt[j][c];
            end
        end
    end

    assign out_stb = stg_vld[mod_r];

    always_comb begin
        for (int c = 0; c < NCH; c++)
            out_nxt[c] = rnd_out(st[mod_r][c]);
    end

    // A clear loads from the incoming coefficients so a simultaneous change is honoured.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vld_nxt   = 1'b0;
        if (i_clr) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = settle_load(i_coef, mod_clamp);
        end else if (cfg_chg) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = settle_load(coef_r, mod_r);
        end else if (out_stb) begin
            if (state == ST_RUN) begin
                vld_nxt = 1'b1;
            end else if (cnt > CNTW'(1)) begin
                cnt_nxt = cnt - CNTW'(1);
            end else begin
                cnt_nxt   = '0;
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_SETTLE;
            cnt     <= settle_load(KW'(0), TW'(0));
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            o_valid <= vld_nxt;
            if (out_stb && !i_clr)
                o_data <= out_nxt;
        end
    end

    assign o_settled = (state == ST_RUN);

endmodule

// File: tb/tb_psd_iir_lpf_cascade.sv
// Scoreboarded bench for psd_iir_lpf_cascade: sample-level reference model feeds an expectation queue,
// a negedge monitor pops and compares data and latency on every o_valid.
module tb_psd_iir_lpf_cascade;

    localparam int DW   = 36;
    localparam int NCH  = 4;
    localparam int NSTG = 4;
    localparam int KW   = 4;
    localparam int MW   = 2;
    localparam int FRAC = 16;
    localparam int CNTW = 24;
    localparam int W    = NCH * DW;

    typedef logic [W-1:0] vec_t;
    typedef struct {
        vec_t   dat;
        longint cyc;
        int     lat;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          clr   = 1'b0;
    vec_t          din   = '0;
    logic [KW-1:0] coef  = '0;
    logic [MW-1:0] mod   = '0;
    vec_t          dout;
    logic          ovld;
    logic          osettled;

    psd_iir_lpf_cascade #(
        .DW(DW), .NCH(NCH), .NSTG(NSTG), .KW(KW), .MW(MW), .FRAC(FRAC), .CNTW(CNTW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .i_data    (din),
        .i_coef    (coef),
        .i_mod     (mod),
        .i_clr     (clr),
        .o_data    (dout),
        .o_valid   (ovld),
        .o_settled (osettled)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_chk  = 0;
    int     n_pass = 0;
    int     n_out  = 0;
    int     cnt0;
    vec_t   last_out = '0;
    exp_t   q[$];
    exp_t   mon_e;

    // Reference state: one value per channel and stage, in FRAC-scaled units.
    longint mst [NCH][NSTG];
    int     mk, mtap, blank;

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic int load_of(input int k, input int t);
        return (t + 1) << (k + 2);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < NSTG; j++)
                mst[c][j] = 0;
        mk = 0; mtap = 0; blank = load_of(0, 0);
        q.delete();
    endtask

    task automatic model_cfg(input int k, input int m);
        int t;
        t = (m > NSTG - 1) ? NSTG - 1 : m;
        if (k != mk || t != mtap) blank = load_of(k, t);
        mk = k; mtap = t;
    endtask

    task automatic send(input vec_t x);
        exp_t   e;
        longint xin, o;
        e.dat = '0;
        for (int c = 0; c < NCH; c++) begin
            xin = longint'($signed(x[c*DW +: DW])) * (longint'(1) << FRAC);
            for (int j = 0; j < NSTG; j++) begin
                if (mk == 0) mst[c][j] = xin;
                else mst[c][j] = mst[c][j] + ((xin - mst[c][j] + (longint'(1) << (mk - 1))) >>> mk);
                xin = mst[c][j];
            end
            o = (mst[c][mtap] + (longint'(1) << (FRAC - 1))) >>> FRAC;
            e.dat[c*DW +: DW] = o[DW-1:0];
        end
        e.cyc = cyc;
        e.lat = 3 + mtap;
        if (blank > 0) blank--;
        else q.push_back(e);
        din   = x;
        valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            valid = 1'b0;
        end
    endtask

    // ch < 0: every channel = val; ch in range: that channel = val, others random; else all random.
    task automatic stream(input int n, input int gap, input int ch, input longint val);
        vec_t          x;
        logic [63:0]   r;
        logic [DW-1:0] v;
        v = val[DW-1:0];
        for (int i = 0; i < n; i++) begin
            tick();
            for (int c = 0; c < NCH; c++) begin
                r = {$urandom(), $urandom()};
                x[c*DW +: DW] = (ch < 0) ? v : r[DW-1:0];
            end
            if (ch >= 0 && ch < NCH) x[ch*DW +: DW] = v;
            send(x);
            idle(gap);
        end
    endtask

    task automatic drain(input string nm);
        idle(12);
        chk(nm, vec_t'(q.size()), '0);
    endtask

    task automatic setcfg(input int k, input int m);
        tick();
        coef  = KW'(k);
        mod   = MW'(m);
        valid = 1'b0;
        model_cfg(k, m);
    endtask

    task automatic clear_with(input int k, input int m);
        tick();
        clr   = 1'b1;
        coef  = KW'(k);
        mod   = MW'(m);
        valid = 1'b0;
        tick();
        clr = 1'b0;
        chk("clr_valid_low", vec_t'(ovld), '0);
        chk("clr_settled_low", vec_t'(osettled), '0);
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < NSTG; j++)
                mst[c][j] = 0;
        mk = k;
        mtap = (m > NSTG - 1) ? NSTG - 1 : m;
        blank = load_of(mk, mtap);
        q.delete();
    endtask

    always @(negedge clk) begin
        if (ovld === 1'b1) begin
            n_out++;
            last_out = dout;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL out_unexpected: got o_valid=1 data %h, expected no output", dout);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", dout, mon_e.dat);
                chk("out_latency", vec_t'(cyc - mon_e.cyc), vec_t'(mon_e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] want;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", dout, '0);
        chk("rst_valid", vec_t'(ovld), '0);
        chk("rst_settled", vec_t'(osettled), '0);
        #1 rst_n = 1'b1;

        // k=0, tap 0, constant 1000: four samples blanked, the rest pass through.
        cnt0 = n_out;
        stream(40, 0, -1, 1000);
        drain("t1_drain");
        chk("t1_count", vec_t'(n_out - cnt0), vec_t'(36));
        chk("t1_settled", vec_t'(osettled), 1'b1);
        want = 36'd1000;
        chk("t1_value", last_out[DW-1:0], want);

        // k=4 step on ch0 after a clear.
        clear_with(4, 0);
        idle(3);
        cnt0 = n_out;
        stream(80, 0, 0, 0);
        stream(400, 0, 0, 65536);
        drain("t2_drain");
        chk("t2_count", vec_t'(n_out - cnt0), vec_t'(480 - 64));
        want = 36'd65536;
        chk("t2_final", last_out[DW-1:0], want);

        // k=3, four stages, -100000 on ch2, valid every third cycle.
        setcfg(3, 3);
        idle(4);
        cnt0 = n_out;
        stream(450, 2, 2, -100000);
        drain("t3_drain");
        chk("t3_count", vec_t'(n_out - cnt0), vec_t'(450 - 128));
        want = -36'sd100000;
        chk("t3_final", last_out[2*DW +: DW], want);
        chk("t3_settled", vec_t'(osettled), 1'b1);

        // Mode change 3 -> 1: settled drops one edge after the registered change, 64 blanked.
        setcfg(3, 1);
        @(posedge clk); #1;
        chk("t4_settled_hold", vec_t'(osettled), 1'b1);
        @(posedge clk); #1;
        chk("t4_settled_drop", vec_t'(osettled), '0);
        idle(2);
        cnt0 = n_out;
        stream(100, 0, 99, 0);
        drain("t4_drain");
        chk("t4_count", vec_t'(n_out - cnt0), vec_t'(100 - 64));
        chk("t4_settled", vec_t'(osettled), 1'b1);

        // Clear mid-stream together with k 3 -> 5 at mod 3: 512 blanked.
        setcfg(3, 3);
        idle(3);
        stream(200, 0, 99, 0);
        clear_with(5, 3);
        cnt0 = n_out;
        stream(600, 0, 99, 0);
        drain("t5_drain");
        chk("t5_count", vec_t'(n_out - cnt0), vec_t'(600 - 512));
        chk("t5_settled", vec_t'(osettled), 1'b1);

        // Asynchronous reset mid-stream.
        stream(20, 0, 99, 0);
        tick();
        send(vec_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", dout, '0);
        chk("t6_rst_valid", vec_t'(ovld), '0);
        chk("t6_rst_settled", vec_t'(osettled), '0);
        coef  = '0;
        mod   = '0;
        valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cnt0 = n_out;
        stream(30, 0, 99, 0);
        drain("t6_drain");
        chk("t6_count", vec_t'(n_out - cnt0), vec_t'(30 - 4));
        chk("t6_settled", vec_t'(osettled), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
